// File: rtl/inst_queue.sv
// inst_queue: decoupling FIFO between IF and ID. Buffers IFreg bus words,
// drops everything on a pipeline flush, and closes to new pushes after an
// entry carrying an exception or refetch tag so no wrong-path fetch queues up.
module inst_queue #(
   parameter int DEPTH    = 4,
   parameter int BUS_LEN  = 81,
   parameter int EBUS_LSB = 65
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       IFreg_valid,
   input  logic                       IF_ready_go,
   input  logic [BUS_LEN-1:0]         IFreg_bus,
   output logic                       IQ_allow_in,
   output logic                       IQ_valid,
   output logic [BUS_LEN-1:0]         IQ_bus,
   input  logic                       ID_allow_in,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] IQ_count,
   output logic                       IQ_blocked
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0][BUS_LEN-1:0] mem;
   logic [PW-1:0]                 head, tail;
   logic [CW-1:0]                 count;
   logic                          blocked;
   logic                          full, push, pop, blk_entry;

   assign full        = (count == CW'(DEPTH));
   assign IQ_valid    = (count != '0) & ~flush;
   assign IQ_bus      = mem[head];
   // A pop in the same cycle frees the slot, so a full queue can still take a push.
   assign IQ_allow_in = ~reset & ~blocked & (~full | (IQ_valid & ID_allow_in));
   assign push        = IQ_allow_in & IF_ready_go & IFreg_valid & ~flush;
   assign pop         = IQ_valid & ID_allow_in & ~flush;
   // Any nonzero exception code or a refetch tag ends the sequential stream.
   assign blk_entry   = (|IFreg_bus[BUS_LEN-1:EBUS_LSB]) | IFreg_bus[0];
   assign IQ_count    = count;
   assign IQ_blocked  = blocked;

   // Pointer/count/blocked state; flush wins over any push or pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         blocked <= 1'b0;
      end else if (flush) begin
         count   <= '0;
         head    <= tail;
         blocked <= 1'b0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         if (push & blk_entry) blocked <= 1'b1;
         if (push & ~pop)      count <= count + CW'(1);
         else if (pop & ~push) count <= count - CW'(1);
      end
   end

   // Entry storage; cleared on reset so IQ_bus reads zero before the first push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     mem       <= '0;
      else if (push) mem[tail] <= IFreg_bus;
   end

   // Occupancy must agree with the pointer distance (full when they meet with count==DEPTH).
   always @(posedge clk) begin
      if (!reset) begin
         if (full) assert (tail == head);
         else      assert (count == CW'(PW'(tail - head)));
      end
   end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed stimulus with a queue-based reference model and
// per-cycle output comparison, plus literal expectations at key points.
module tb_inst_queue;

   localparam int DEPTH = 4;
   localparam int BL    = 81;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          IFreg_valid = 1'b0;
   logic          IF_ready_go = 1'b0;
   logic [BL-1:0] IFreg_bus = '0;
   logic          IQ_allow_in;
   logic          IQ_valid;
   logic [BL-1:0] IQ_bus;
   logic          ID_allow_in = 1'b0;
   logic          flush = 1'b0;
   logic [2:0]    IQ_count;
   logic          IQ_blocked;

   int passed = 0;
   int total  = 0;

   inst_queue #(.DEPTH(DEPTH), .BUS_LEN(BL), .EBUS_LSB(65)) dut (
      .clk(clk), .reset(reset), .IFreg_valid(IFreg_valid), .IF_ready_go(IF_ready_go),
      .IFreg_bus(IFreg_bus), .IQ_allow_in(IQ_allow_in), .IQ_valid(IQ_valid),
      .IQ_bus(IQ_bus), .ID_allow_in(ID_allow_in), .flush(flush),
      .IQ_count(IQ_count), .IQ_blocked(IQ_blocked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [BL-1:0] act, input logic [BL-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [BL-1:0] mk(input logic [15:0] ebus, input logic [31:0] pc, input logic rf);
      return {ebus, pc ^ 32'h13579bdf, pc, rf};
   endfunction

   // ---------------- reference model: a plain queue of entries ----------------
   logic [BL-1:0] q[$];
   bit            mblk = 0;

   function automatic bit m_valid();
      return (q.size() != 0) && !flush;
   endfunction

   function automatic bit m_allow();
      return !reset && !mblk && ((q.size() < DEPTH) || (m_valid() && ID_allow_in));
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q.delete();
         mblk = 0;
      end else if (flush) begin
         q.delete();
         mblk = 0;
      end else begin
         bit do_pop, do_push;
         do_pop  = m_valid() && ID_allow_in;
         do_push = m_allow() && IF_ready_go && IFreg_valid;
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            q.push_back(IFreg_bus);
            if (IFreg_bus[80:65] != 0 || IFreg_bus[0]) mblk = 1;
         end
      end
   end

   // Compare every cycle away from the active edge.
   always @(negedge clk) begin
      chk("valid",   {80'b0, IQ_valid},    {80'b0, m_valid()});
      chk("count",   {78'b0, IQ_count},    BL'(q.size()));
      chk("blocked", {80'b0, IQ_blocked},  {80'b0, mblk});
      chk("allow",   {80'b0, IQ_allow_in}, {80'b0, m_allow()});
      if (q.size() != 0) chk("bus", IQ_bus, q[0]);
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drive(input bit v, input bit rg, input logic [BL-1:0] b, input bit ida, input bit fl);
      IFreg_valid = v; IF_ready_go = rg; IFreg_bus = b; ID_allow_in = ida; flush = fl;
   endtask

   initial begin
      // Reset state
      step(); step();
      chk("rst_valid", {80'b0, IQ_valid}, 0);
      chk("rst_count", {78'b0, IQ_count}, 0);
      chk("rst_allow", {80'b0, IQ_allow_in}, 0);
      chk("rst_bus",   IQ_bus, 0);
      reset = 1'b0; #1;
      chk("post_rst_allow", {80'b0, IQ_allow_in}, 1);

      // Fill then drain
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, mk(0, 32'h1c000000 + 32'(4*i), 0), 0, 0);
         step();
      end
      drive(0, 1, '0, 0, 0); #1;
      chk("fill_count", {78'b0, IQ_count}, 4);
      chk("fill_allow", {80'b0, IQ_allow_in}, 0);
      ID_allow_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 chk("drain_pc", {49'b0, IQ_bus[32:1]}, BL'(32'h1c000000 + 32'(4*i)));
         step();
      end
      chk("drain_count", {78'b0, IQ_count}, 0);
      chk("drain_valid", {80'b0, IQ_valid}, 0);

      // Full with simultaneous push/pop, then wrap for 10 cycles
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, mk(0, 32'h1c000000 + 32'(4*i), 0), 0, 0);
         step();
      end
      drive(1, 1, mk(0, 32'h1c000010, 0), 1, 0); #1;
      chk("full_pp_allow", {80'b0, IQ_allow_in}, 1);
      step();
      chk("full_pp_count", {78'b0, IQ_count}, 4);
      chk("full_pp_head",  {49'b0, IQ_bus[32:1]}, BL'(32'h1c000004));
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, mk(0, 32'h1c000014 + 32'(4*i), 0), 1, 0);
         step();
      end
      chk("wrap_head", {49'b0, IQ_bus[32:1]}, BL'(32'h1c00002c));
      drive(0, 1, '0, 1, 0);
      repeat (5) step();

      // Flush mid-stream with push and pop
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, mk(0, 32'h1c000100 + 32'(4*i), 0), 0, 0);
         step();
      end
      drive(1, 1, mk(0, 32'h1c00010c, 0), 1, 1); #1;
      chk("flush_valid_same", {80'b0, IQ_valid}, 0);
      step();
      drive(0, 1, '0, 1, 0); #1;
      chk("flush_count", {78'b0, IQ_count}, 0);
      chk("flush_valid", {80'b0, IQ_valid}, 0);
      step();

      // Exception block
      drive(1, 1, mk(16'h0001, 32'h1c000018, 0), 0, 0);
      step();
      drive(1, 1, mk(0, 32'h1c000020, 0), 0, 0); #1;
      chk("exc_blocked", {80'b0, IQ_blocked}, 1);
      chk("exc_allow",   {80'b0, IQ_allow_in}, 0);
      step();
      chk("exc_count", {78'b0, IQ_count}, 1);
      ID_allow_in = 1'b1; #1;
      chk("exc_ebus", {65'b0, IQ_bus[80:65]}, 1);
      chk("exc_pc",   {49'b0, IQ_bus[32:1]}, BL'(32'h1c000018));
      step();
      chk("exc_drained", {78'b0, IQ_count}, 0);
      chk("exc_still_blk", {80'b0, IQ_blocked}, 1);
      drive(0, 1, '0, 0, 1);
      step();
      drive(1, 1, mk(0, 32'h1c000020, 0), 0, 0); #1;
      chk("exc_unblk_allow", {80'b0, IQ_allow_in}, 1);
      step();
      chk("exc_repush_count", {78'b0, IQ_count}, 1);
      drive(0, 1, '0, 1, 0);
      step();

      // Refetch block and IF_ready_go=0 hold
      drive(1, 1, mk(0, 32'h1c000024, 1), 0, 0);
      step();
      chk("rf_blocked", {80'b0, IQ_blocked}, 1);
      chk("rf_allow",   {80'b0, IQ_allow_in}, 0);
      drive(0, 1, '0, 0, 1);
      step();
      drive(1, 0, mk(0, 32'h1c000028, 0), 0, 0);
      step(); step();
      chk("nrg_count", {78'b0, IQ_count}, 0);
      IF_ready_go = 1'b1;
      step();
      chk("rg_count", {78'b0, IQ_count}, 1);

      // Async reset with count=2 and blocked
      drive(1, 1, mk(0, 32'h1c00002c, 1), 0, 0);
      step();
      drive(0, 1, '0, 0, 0);
      chk("pre_rst_count", {78'b0, IQ_count}, 2);
      chk("pre_rst_blk",   {80'b0, IQ_blocked}, 1);
      #1 reset = 1'b1; #1;
      chk("arst_valid", {80'b0, IQ_valid}, 0);
      chk("arst_count", {78'b0, IQ_count}, 0);
      chk("arst_blk",   {80'b0, IQ_blocked}, 0);
      step();
      reset = 1'b0;
      drive(1, 1, mk(0, 32'h1c000030, 0), 0, 0); #1;
      chk("rst_push_notyet", {80'b0, IQ_valid}, 0);
      step();
      drive(0, 1, '0, 0, 0); #1;
      chk("rst_push_valid", {80'b0, IQ_valid}, 1);
      chk("rst_push_pc", {49'b0, IQ_bus[32:1]}, BL'(32'h1c000030));
      step(); step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Decoupling FIFO between the IF stage and the ID stage.
- Buffers IFreg bus words ({ebus, inst, pc, refetch_tag}) so fetch can run ahead while ID stalls.
- Discards all buffered entries on any pipeline flush: branch, exception, ertn or refetch.
- Stops accepting new entries after one that carries an exception or a refetch tag, so no wrong-path fetch is buffered behind it.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- BUS_LEN, 81, IFreg bus width: ebus[80:65], inst[64:33], pc[32:1], refetch_tag[0].
- EBUS_LSB, 65, bit position of ebus[0] within the bus.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- IFreg_valid  in  1  IF holds a valid entry.
- IF_ready_go  in  1  IF entry is complete (inst available).
- IFreg_bus  in  BUS_LEN  entry payload.
- IQ_allow_in  out  1  queue accepts a push this cycle (drives IF's ID_allow_in).
- IQ_valid  out  1  head entry valid toward ID.
- IQ_bus  out  BUS_LEN  head entry payload.
- ID_allow_in  in  1  ID consumes head this cycle.
- flush  in  1  discard everything (br_taken | ex | ertn | refetch_flush).
- IQ_count  out  $clog2(DEPTH+1)  current occupancy.
- IQ_blocked  out  1  queue is closed to pushes after an exception/refetch entry.

Behaviour:
- Reset (async, immediate): count=0, head/tail pointers=0, blocked=0. Outputs: IQ_valid=0, IQ_count=0, IQ_blocked=0, IQ_allow_in=0 while reset is high. IQ_bus=0 from reset until the first push.
- Storage: DEPTH-entry register array, circular head/tail pointers of log2(DEPTH) bits, wrapping naturally. Payload is never modified.
- IQ_allow_in = ~reset & ~blocked & (count<DEPTH | (IQ_valid & ID_allow_in)). Simultaneous pop enables a push into a full queue.
- push = IQ_allow_in & IF_ready_go & IFreg_valid & ~flush.
- pop = IQ_valid & ID_allow_in & ~flush.
- IQ_valid = (count!=0) & ~flush. IQ_bus = mem[head], combinational from the register array.
- Latency: an entry pushed in cycle N is visible at IQ_valid/IQ_bus in cycle N+1. No same-cycle bypass.
- Count update: push&~pop → +1; pop&~push → −1; both or neither → unchanged. Count never exceeds DEPTH and never underflows.
- Pushing while IF_ready_go=0 or IFreg_valid=0 does nothing. IF retains its entry.
- Blocking: if a pushed entry has ebus!=0 or refetch_tag=1, set blocked=1 at the clock edge. IQ_allow_in then stays 0 until a flush. Entries already queued still drain to ID normally.
- Flush (highest priority): at the clock edge, count←0, head←tail, blocked←0. Any same-cycle push or pop is suppressed. IQ_valid is forced to 0 in the flush cycle itself. IQ_allow_in remains as computed (IF cancels its own entry on the same flush).
- Flush arriving while the queue is empty or blocked is legal and behaves identically.
- Reset mid-operation loses all entries. No pending state survives.
- Invariant (checked by assertion): count == (tail−head) mod DEPTH, except count==DEPTH when tail==head and the queue is full. Implementation keeps an explicit count register.

Test Plan:
- Fill/drain: ID_allow_in=0. Push pc 0x1c000000, 0x1c000004, 0x1c000008, 0x1c00000c with valid=ready_go=1 → count 1..4, IQ_allow_in=0 at count 4. Then ID_allow_in=1 → pcs pop in order, one per cycle; count returns to 0; IQ_valid=0.
- Full with simultaneous push/pop: count=4, ID_allow_in=1, push pc 0x1c000010 → IQ_allow_in=1, count stays 4, head advances, new tail holds 0x1c000010. Wrap-around verified over 10 continuous cycles with no loss or duplication.
- Flush mid-stream: count=3, assert flush together with push and pop → next cycle count=0, IQ_valid=0, pushed entry absent. IQ_valid=0 during the flush cycle.
- Exception block: push entry with ADEF bit set in ebus, then try pc 0x1c000020 → IQ_blocked=1, IQ_allow_in=0, ADEF entry reaches ID. flush → blocked=0, next push is accepted.
- Refetch block: push entry with refetch_tag=1 → same blocking as the exception case. IF_ready_go=0 with IFreg_valid=1 causes no push and count is unchanged.
- Async reset: assert reset between clock edges with count=2 → IQ_valid, IQ_count and IQ_blocked drop to 0 immediately without waiting for a clock edge. After deassert, the first push appears one cycle later.
